// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: multiplies x/y by KCOEF/2^FRAC with a bit-serial shift-add.
// Define CORDIC_GAIN_SAT_EN to clip out-of-range results and report them on sat.
module cordic_gain_comp #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned COEF_W = 13,
  parameter int unsigned KCOEF  = 2487,
  parameter int unsigned FRAC   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic              sat
);

  localparam int unsigned ACC_W = DATA_W + COEF_W;
  localparam int unsigned RND_W = ACC_W + 1;
  localparam int unsigned CNT_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;
  localparam logic [COEF_W-1:0]       K_BITS   = COEF_W'(KCOEF);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(COEF_W - 1);
  localparam logic signed [RND_W-1:0] HALF     = RND_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x_r, y_r;
  logic signed [ACC_W-1:0]  acc_x, acc_y, acc_x_nxt, acc_y_nxt, x_ext, y_ext;
  logic [CNT_W-1:0]         cnt;
  logic signed [RND_W-1:0]  rx, ry;
  logic signed [DATA_W-1:0] x_fin, y_fin, x_q, y_q;
  logic                     sat_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)        state_nxt = S_MUL;
      S_MUL:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  if (out_ready)       state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Final result is taken from the post-add accumulator so the last coefficient bit counts.
  always_comb begin
    x_ext     = {{(ACC_W-DATA_W){x_r[DATA_W-1]}}, x_r};
    y_ext     = {{(ACC_W-DATA_W){y_r[DATA_W-1]}}, y_r};
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    if (K_BITS[cnt]) begin
      acc_x_nxt = acc_x + (x_ext <<< cnt);
      acc_y_nxt = acc_y + (y_ext <<< cnt);
    end
    rx = ($signed({acc_x_nxt[ACC_W-1], acc_x_nxt}) + HALF) >>> FRAC;
    ry = ($signed({acc_y_nxt[ACC_W-1], acc_y_nxt}) + HALF) >>> FRAC;
  end

`ifdef CORDIC_GAIN_SAT_EN
  localparam logic signed [RND_W-1:0] MAX_V = RND_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    sat_fin = 1'b0;
    x_fin   = rx[DATA_W-1:0];
    y_fin   = ry[DATA_W-1:0];
    if (rx > MAX_V) begin
      x_fin = MAX_V[DATA_W-1:0]; sat_fin = 1'b1;
    end else if (rx < MIN_V) begin
      x_fin = MIN_V[DATA_W-1:0]; sat_fin = 1'b1;
    end
    if (ry > MAX_V) begin
      y_fin = MAX_V[DATA_W-1:0]; sat_fin = 1'b1;
    end else if (ry < MIN_V) begin
      y_fin = MIN_V[DATA_W-1:0]; sat_fin = 1'b1;
    end
  end
`else
  logic unused_hi;

  always_comb begin
    x_fin   = rx[DATA_W-1:0];
    y_fin   = ry[DATA_W-1:0];
    sat_fin = 1'b0;
  end

  assign unused_hi = ^{rx[RND_W-1:DATA_W], ry[RND_W-1:DATA_W], sat_fin};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= '0;
      y_r   <= '0;
      acc_x <= '0;
      acc_y <= '0;
      cnt   <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          x_r   <= x_in;
          y_r   <= y_in;
          acc_x <= '0;
          acc_y <= '0;
          cnt   <= '0;
        end
        S_MUL: begin
          acc_x <= acc_x_nxt;
          acc_y <= acc_y_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            x_q <= x_fin;
            y_q <= y_fin;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CORDIC_GAIN_SAT_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                sat_q <= 1'b0;
    else if (state == S_MUL && cnt == CNT_LAST) sat_q <= sat_fin;
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign x_out = x_q;
  assign y_out = y_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: directed table, backpressure, reset abort,
// large-coefficient overflow case and a randomized stream against an arithmetic model.
module tb_cordic_gain_comp;

  localparam int DATA_W = 13;
  localparam int COEF_W = 13;
  localparam int KCOEF  = 2487;
  localparam int FRAC   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, out_valid, out_ready, sat;
  logic [DATA_W-1:0] x_in, y_in, x_out, y_out;
  logic k_in_valid, k_in_ready, k_out_valid, k_out_ready, k_sat;
  logic [DATA_W-1:0] k_x_in, k_y_in, k_x_out, k_y_out;

  cordic_gain_comp #(.DATA_W(DATA_W), .COEF_W(COEF_W), .KCOEF(KCOEF), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .sat(sat)
  );

  cordic_gain_comp #(.DATA_W(DATA_W), .COEF_W(COEF_W), .KCOEF(8191), .FRAC(FRAC)) dut_k (
    .clk(clk), .rst_n(rst_n), .in_valid(k_in_valid), .in_ready(k_in_ready),
    .x_in(k_x_in), .y_in(k_y_in), .out_valid(k_out_valid), .out_ready(k_out_ready),
    .x_out(k_x_out), .y_out(k_y_out), .sat(k_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int x;
    int y;
    int ex;
    int ey;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference: round-half-up of v*k/2^FRAC, then clip or wrap into DATA_W bits.
  function automatic int model(input int v, input int k, output int s);
    longint n, d, q;
    d = longint'(1) << FRAC;
    n = longint'(v) * longint'(k) + d / 2;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    s = 0;
`ifdef CORDIC_GAIN_SAT_EN
    if (q > 4095)  begin q = 4095;  s = 1; end
    if (q < -4096) begin q = -4096; s = 1; end
`else
    q = ((q % 8192) + 8192) % 8192;
    if (q >= 4096) q = q - 8192;
`endif
    return int'(q);
  endfunction

  function automatic logic [DATA_W-1:0] rnd13();
    logic [DATA_W-1:0] v;
    case ($urandom % 8)
      0:       v = 13'h0FFF;
      1:       v = 13'h1000;
      default: v = DATA_W'($urandom);
    endcase
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    if (!in_ready) chk(name, in_ready, 1);
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    chk(name, n, 13);
  endtask

  task automatic run_one(input string name, input int x, input int y, input int ex, input int ey);
    out_ready = 1'b1;
    wait_ready({name, "_ready"});
    in_valid = 1'b1;
    x_in = DATA_W'(x);
    y_in = DATA_W'(y);
    tick();
    in_valid = 1'b0;
    chk({name, "_busy"}, in_ready, 0);
    wait_out({name, "_latency"});
    chk({name, "_x"}, sx(x_out), ex);
    chk({name, "_y"}, sx(y_out), ey);
    chk({name, "_sat"}, sat, 0);
    tick();
    chk({name, "_drain_valid"}, out_valid, 0);
    chk({name, "_drain_ready"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    int q_x[$], q_y[$], q_s[$];
    int acc_n, out_n, cyc, n, ex, ey, es, s;
    bit a, d;
    logic [DATA_W-1:0] ox, oy;
    logic os;

    vecs[0] = '{1000, 0, 607, 0};
    vecs[1] = '{-1000, 4095, -607, 2486};
    vecs[2] = '{0, -4096, 0, -2487};
    vecs[3] = '{2048, -2048, 1244, -1243};
    vecs[4] = '{1, -1, 1, -1};

    in_valid = 1'b0; x_in = '0; y_in = '0; out_ready = 1'b1;
    k_in_valid = 1'b0; k_x_in = '0; k_y_in = '0; k_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", sx(x_out), 0);
    chk("rst_y", sx(y_out), 0);
    chk("rst_sat", sat, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 5; i++)
      run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].ex, vecs[i].ey);

    // Backpressure with in_valid held and inputs toggling.
    out_ready = 1'b0;
    in_valid = 1'b1;
    x_in = DATA_W'(1500);
    y_in = DATA_W'(-700);
    tick();
    n = 0;
    while (!out_valid && n < 40) begin
      chk("bp_busy_mul", in_ready, 0);
      x_in = rnd13();
      y_in = rnd13();
      tick();
      n++;
    end
    chk("bp_latency", n, 13);
    for (int i = 0; i < 20; i++) begin
      x_in = rnd13();
      y_in = rnd13();
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_x", sx(x_out), 911);
      chk("bp_y", sx(y_out), -425);
    end
    out_ready = 1'b1;
    x_in = DATA_W'(1000);
    y_in = DATA_W'(0);
    tick();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_drain_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", in_ready, 0);
    wait_out("bp_new_latency");
    chk("bp_new_x", sx(x_out), 607);
    chk("bp_new_y", sx(y_out), 0);
    tick();

    // Maximum coefficient: product exceeds the output range.
    k_in_valid = 1'b1;
    k_x_in = DATA_W'(4000);
    k_y_in = DATA_W'(0);
    tick();
    k_in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!k_out_valid && n < 40);
    chk("kmax_latency", n, 13);
`ifdef CORDIC_GAIN_SAT_EN
    chk("kmax_x", sx(k_x_out), 4095);
    chk("kmax_sat", k_sat, 1);
`else
    chk("kmax_x", sx(k_x_out), -193);
    chk("kmax_sat", k_sat, 0);
`endif
    chk("kmax_y", sx(k_y_out), 0);
    tick();
    chk("kmax_drain", k_out_valid, 0);

    // Reset asserted mid-multiply.
    wait_ready("rst_mid_ready");
    in_valid = 1'b1;
    x_in = DATA_W'(1000);
    y_in = DATA_W'(-1000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_x", sx(x_out), 0);
    chk("rst_mid_y", sx(y_out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_no_out", out_valid, 0);
    run_one("post_rst", 1000, 0, 607, 0);

    // Randomized stream with random backpressure.
    acc_n = 0; out_n = 0; cyc = 0;
    in_valid = 1'b1;
    x_in = rnd13();
    y_in = rnd13();
    while ((acc_n < 50 || out_n < acc_n) && cyc < 5000) begin
      out_ready = 1'($urandom % 2);
      a = in_valid && in_ready;
      d = out_valid && out_ready;
      ox = x_out; oy = y_out; os = sat;
      tick();
      cyc++;
      if (a) begin
        ex = model(sx(x_in), KCOEF, es);
        ey = model(sx(y_in), KCOEF, s);
        q_x.push_back(ex);
        q_y.push_back(ey);
        q_s.push_back(es | s);
        acc_n++;
        if (acc_n == 50) in_valid = 1'b0;
      end
      if (d) begin
        if (q_x.size() == 0) begin
          chk("stream_unexpected_out", out_n, acc_n - 1);
        end else begin
          chk($sformatf("stream%0d_x", out_n), sx(ox), q_x.pop_front());
          chk($sformatf("stream%0d_y", out_n), sx(oy), q_y.pop_front());
          chk($sformatf("stream%0d_sat", out_n), os, q_s.pop_front());
        end
        out_n++;
      end
      x_in = rnd13();
      y_in = rnd13();
    end
    in_valid = 1'b0;
    chk("stream_accepted", acc_n, 50);
    chk("stream_emitted", out_n, 50);
    chk("stream_leftover", q_x.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
